// File: rtl/ap_prof_pkg.sv
// Shared types for the HLS handshake profiler: channel FSM states,
// readout selector codes, the per-channel statistic record and a
// saturating increment helper.
package ap_prof_pkg;

  // Widest counter supported; narrower CNT_W values use the low bits only.
  localparam int MAX_CNT_W = 32;

  typedef logic [MAX_CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY      = 2'd1,
    DONE_WAIT = 2'd2
  } ch_state_e;

  localparam logic [2:0] RD_SEL_START = 3'd0;
  localparam logic [2:0] RD_SEL_DONE  = 3'd1;
  localparam logic [2:0] RD_SEL_BUSY  = 3'd2;
  localparam logic [2:0] RD_SEL_STALL = 3'd3;
  localparam logic [2:0] RD_SEL_LAST  = 3'd4;
  localparam logic [2:0] RD_SEL_MAX   = 3'd5;
  localparam logic [2:0] RD_SEL_MIN   = 3'd6;
  localparam logic [2:0] RD_SEL_READY = 3'd7;

  typedef struct packed {
    cnt_t start_cnt;
    cnt_t done_cnt;
    cnt_t busy_cyc;
    cnt_t stall_cyc;
    cnt_t last_lat;
    cnt_t max_lat;
    cnt_t min_lat;
  } stat_t;

  // Increment that sticks at max_v instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v, input cnt_t max_v);
    return (v >= max_v) ? v : v + cnt_t'(1);
  endfunction

  // All-ones value of a w-bit counter, held in a full-width word.
  function automatic cnt_t cnt_max(input int w);
    return (w >= MAX_CNT_W) ? '1 : ((cnt_t'(1) << w) - cnt_t'(1));
  endfunction

endpackage

// File: rtl/ap_prof_channel.sv
// One monitored HLS sub-module: tracks the start/done/continue handshake
// in a small FSM and accumulates saturating statistics. The FSM and the
// running latency keep going while statistics are frozen or cleared so an
// in-flight transaction still reports its true latency afterwards.
module ap_prof_channel
  import ap_prof_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  ap_start,
  input  logic  ap_ready,
  input  logic  ap_done,
  input  logic  cont,
  input  logic  upd_en,
  input  logic  clear,
  output stat_t stat,
  output cnt_t  ready_cnt,
  output logic  err
);

  localparam cnt_t MAX_V = cnt_max(CNT_W);
  localparam cnt_t ONE   = cnt_t'(1);

  ch_state_e state_reg, state_next;
  cnt_t      lat_reg, lat_next;
  stat_t     stat_reg, stat_next;
  cnt_t      ready_reg, ready_next;
  logic      err_reg, err_next;

  logic start_ev, done_ev, busy_ev, stall_ev, err_ev;
  cnt_t done_lat;

  // Handshake FSM: next state, running latency and the events of this cycle
  always_comb begin
    state_next = state_reg;
    lat_next   = lat_reg;
    start_ev   = 1'b0;
    done_ev    = 1'b0;
    busy_ev    = 1'b0;
    stall_ev   = 1'b0;
    err_ev     = 1'b0;
    done_lat   = ONE;
    case (state_reg)
      IDLE: begin
        if (ap_start) begin
          start_ev = 1'b1;
          lat_next = ONE;
          if (ap_done) begin
            // single-cycle transaction
            done_ev    = 1'b1;
            done_lat   = ONE;
            state_next = cont ? IDLE : DONE_WAIT;
          end else begin
            state_next = BUSY;
          end
        end else if (ap_done) begin
          // done without any transaction in flight
          err_ev = 1'b1;
        end
      end
      BUSY: begin
        busy_ev  = 1'b1;
        lat_next = sat_inc(lat_reg, MAX_V);
        if (ap_done) begin
          done_ev  = 1'b1;
          done_lat = sat_inc(lat_reg, MAX_V);
          if (!cont) begin
            state_next = DONE_WAIT;
          end else if (ap_start) begin
            start_ev   = 1'b1;
            lat_next   = ONE;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DONE_WAIT: begin
        stall_ev = 1'b1;
        if (cont) begin
          if (ap_start) begin
            start_ev   = 1'b1;
            lat_next   = ONE;
            state_next = BUSY;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Statistic update from this cycle's events; clear beats any update
  always_comb begin
    stat_next  = stat_reg;
    ready_next = ready_reg;
    err_next   = err_reg;
    if (clear) begin
      stat_next         = '0;
      stat_next.min_lat = MAX_V;
      ready_next        = '0;
      err_next          = 1'b0;
    end else begin
      if (upd_en) begin
        if (start_ev) stat_next.start_cnt = sat_inc(stat_reg.start_cnt, MAX_V);
        if (busy_ev)  stat_next.busy_cyc  = sat_inc(stat_reg.busy_cyc, MAX_V);
        if (stall_ev) stat_next.stall_cyc = sat_inc(stat_reg.stall_cyc, MAX_V);
        if (ap_ready) ready_next          = sat_inc(ready_reg, MAX_V);
        if (done_ev) begin
          stat_next.done_cnt = sat_inc(stat_reg.done_cnt, MAX_V);
          stat_next.last_lat = done_lat;
          if (done_lat > stat_reg.max_lat) stat_next.max_lat = done_lat;
          if (done_lat < stat_reg.min_lat) stat_next.min_lat = done_lat;
        end
      end
      if (err_ev) err_next = 1'b1;
    end
  end

  // State and statistic registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg        <= IDLE;
      lat_reg          <= '0;
      stat_reg         <= '0;
      stat_reg.min_lat <= MAX_V;
      ready_reg        <= '0;
      err_reg          <= 1'b0;
    end else begin
      state_reg <= state_next;
      lat_reg   <= lat_next;
      stat_reg  <= stat_next;
      ready_reg <= ready_next;
      err_reg   <= err_next;
    end
  end

  assign stat      = stat_reg;
  assign ready_cnt = ready_reg;
  assign err       = err_reg;

endmodule

// File: rtl/ap_module_profiler.sv
// Hardware profiler for N_CH HLS sub-modules: one statistics channel per
// sub-module, a sticky freeze/clear control and a registered readout port.
// Readout slots beyond N_CH are tied to zero so an out-of-range channel
// index reads back 0 without any extra range compare.
module ap_module_profiler
  import ap_prof_pkg::*;
#(
  parameter int              N_CH      = 14,
  parameter int              CNT_W     = 32,
  parameter logic [N_CH-1:0] CONT_MASK = {N_CH{1'b1}},
  parameter int              CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_CH-1:0]  ap_start,
  input  logic [N_CH-1:0]  ap_ready,
  input  logic [N_CH-1:0]  ap_done,
  input  logic [N_CH-1:0]  ap_continue,
  input  logic             finish,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [CH_W-1:0]  rd_ch,
  input  logic [2:0]       rd_sel,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             frozen,
  output logic [N_CH-1:0]  err
);

  localparam int N_SLOT = 1 << CH_W;

  logic             frozen_reg;
  logic             rd_valid_reg;
  logic [CNT_W-1:0] rd_data_reg;

  stat_t ch_stat  [N_SLOT];
  cnt_t  ch_ready [N_SLOT];
  cnt_t  sel_val;

  generate
    for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_ch
      if (gi < N_CH) begin : g_live
        ap_prof_channel #(
          .CNT_W(CNT_W)
        ) u_ch (
          .clock     (clock),
          .reset     (reset),
          .ap_start  (ap_start[gi]),
          .ap_ready  (ap_ready[gi]),
          .ap_done   (ap_done[gi]),
          .cont      (ap_continue[gi] | CONT_MASK[gi]),
          .upd_en    (~frozen_reg),
          .clear     (clear),
          .stat      (ch_stat[gi]),
          .ready_cnt (ch_ready[gi]),
          .err       (err[gi])
        );
      end else begin : g_pad
        assign ch_stat[gi]  = '0;
        assign ch_ready[gi] = '0;
      end
    end
  endgenerate

  // Select the requested statistic from the current (pre-update) values
  always_comb begin
    sel_val = '0;
    case (rd_sel)
      RD_SEL_START: sel_val = ch_stat[rd_ch].start_cnt;
      RD_SEL_DONE:  sel_val = ch_stat[rd_ch].done_cnt;
      RD_SEL_BUSY:  sel_val = ch_stat[rd_ch].busy_cyc;
      RD_SEL_STALL: sel_val = ch_stat[rd_ch].stall_cyc;
      RD_SEL_LAST:  sel_val = ch_stat[rd_ch].last_lat;
      RD_SEL_MAX:   sel_val = ch_stat[rd_ch].max_lat;
      RD_SEL_MIN:   sel_val = ch_stat[rd_ch].min_lat;
      RD_SEL_READY: sel_val = ch_ready[rd_ch];
      default:      sel_val = '0;
    endcase
  end

  // Freeze is sticky until clear; clear also wins over a same-cycle finish
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frozen_reg <= 1'b0;
    end else if (clear) begin
      frozen_reg <= 1'b0;
    end else if (finish) begin
      frozen_reg <= 1'b1;
    end
  end

  // One-cycle registered readout; data holds when no read is requested
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
    end else begin
      rd_valid_reg <= rd_en;
      if (rd_en) rd_data_reg <= sel_val[CNT_W-1:0];
    end
  end

  assign frozen   = frozen_reg;
  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;

endmodule
